// File: rtl/cbfp_pkg.sv
// Shared widths, types and helpers for the CBFP normalization stage.
package cbfp_pkg;
    localparam int LANES     = 8;
    localparam int LZC_WIDTH = 5;
    localparam int IN_W      = 23;
    localparam int OUT_W     = 11;

    typedef logic [LZC_WIDTH-1:0]    lzc_t;
    typedef logic signed [IN_W-1:0]  smp_in_t;
    typedef logic signed [OUT_W-1:0] smp_out_t;

    typedef struct packed {
        logic                        valid;
        logic [LANES-1:0][IN_W-1:0]  re;
        logic [LANES-1:0][IN_W-1:0]  im;
    } grp_in_t;

    // A shift of IN_W-1 already moves the LSB into the sign position.
    function automatic lzc_t clamp_shift(input lzc_t lzc);
        return (lzc > lzc_t'(IN_W - 1)) ? lzc_t'(IN_W - 1) : lzc;
    endfunction
endpackage

// File: rtl/cbfp_exp_fifo.sv
// Exponent FIFO: synchronous, power-of-2 depth, with push-while-full overflow pulse.
module cbfp_exp_fifo
    import cbfp_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic rstn,
    input  logic push,
    input  lzc_t din,
    input  logic pop_req,
    output lzc_t dout,
    output logic valid,
    output logic full,
    output logic ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    lzc_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          empty;
    logic          pop;
    logic          push_ok;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign pop     = pop_req && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok = push && (!full || pop);
    assign ovf     = push && full && !pop;
    assign valid   = !empty;
    assign dout    = empty ? '0 : mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; the empty-gated dout keeps stale entries invisible.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/cbfp_norm_8in.sv
// CBFP normalizer: delays 8 complex samples until the group min LZC arrives,
// left-shifts and truncates them, and queues the applied exponent.
module cbfp_norm_8in
    import cbfp_pkg::*;
#(
    parameter int MIN_LAT   = 1,
    parameter int EXP_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        en,
    input  logic                        in_valid,
    input  logic [LANES-1:0][IN_W-1:0]  in_re,
    input  logic [LANES-1:0][IN_W-1:0]  in_im,
    input  logic                        min_valid,
    input  logic [LZC_WIDTH-1:0]        min_lzc,
    output logic                        out_valid,
    output logic [LANES-1:0][OUT_W-1:0] out_re,
    output logic [LANES-1:0][OUT_W-1:0] out_im,
    output logic                        exp_valid,
    input  logic                        exp_ready,
    output logic [LZC_WIDTH-1:0]        exp_out,
    output logic                        exp_full,
    output logic                        err_sync,
    output logic                        err_ovf
);
    grp_in_t dl [MIN_LAT];
    grp_in_t d_grp;

    for (genvar k = 0; k < MIN_LAT; k++) begin : g_dl
        if (k == 0) begin : g_head
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)   dl[0] <= '0;
                else if (en) dl[0] <= '{valid: in_valid, re: in_re, im: in_im};
            end
        end else begin : g_tail
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)   dl[k] <= '0;
                else if (en) dl[k] <= dl[k-1];
            end
        end
    end

    assign d_grp = dl[MIN_LAT-1];

    lzc_t                        sh;
    logic                        fire;
    logic                        ovf;
    logic [LANES-1:0][OUT_W-1:0] nxt_re;
    logic [LANES-1:0][OUT_W-1:0] nxt_im;

    assign sh   = clamp_shift(min_lzc);
    assign fire = en && d_grp.valid && min_valid;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        smp_in_t t_re;
        smp_in_t t_im;
        assign t_re      = d_grp.re[l] << sh;
        assign t_im      = d_grp.im[l] << sh;
        assign nxt_re[l] = t_re[IN_W-1 -: OUT_W];
        assign nxt_im[l] = t_im[IN_W-1 -: OUT_W];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            err_sync  <= 1'b0;
            err_ovf   <= 1'b0;
        end else begin
            if (en) out_valid <= fire;
            if (fire) begin
                out_re <= nxt_re;
                out_im <= nxt_im;
            end
            // A group without its lzc (or the reverse) means the two pipes slipped.
            if (en && (d_grp.valid != min_valid)) err_sync <= 1'b1;
            if (ovf) err_ovf <= 1'b1;
        end
    end

    cbfp_exp_fifo #(
        .DEPTH (EXP_DEPTH)
    ) u_exp_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push    (fire),
        .din     (sh),
        .pop_req (exp_ready),
        .dout    (exp_out),
        .valid   (exp_valid),
        .full    (exp_full),
        .ovf     (ovf)
    );
endmodule

// File: tb/tb_cbfp_norm_8in.sv
// Directed bench for cbfp_norm_8in: table of single-lane groups plus FIFO, sync-error, stall and reset sequences.
module tb_cbfp_norm_8in;
    import cbfp_pkg::*;

    logic                        clk = 1'b0;
    logic                        rstn;
    logic                        en;
    logic                        in_valid;
    logic [LANES-1:0][IN_W-1:0]  in_re;
    logic [LANES-1:0][IN_W-1:0]  in_im;
    logic                        min_valid;
    logic [LZC_WIDTH-1:0]        min_lzc;
    logic                        out_valid;
    logic [LANES-1:0][OUT_W-1:0] out_re;
    logic [LANES-1:0][OUT_W-1:0] out_im;
    logic                        exp_valid;
    logic                        exp_ready;
    logic [LZC_WIDTH-1:0]        exp_out;
    logic                        exp_full;
    logic                        err_sync;
    logic                        err_ovf;

    int checks   = 0;
    int failures = 0;

    cbfp_norm_8in #(.MIN_LAT(1), .EXP_DEPTH(8)) dut (
        .clk(clk), .rstn(rstn), .en(en), .in_valid(in_valid),
        .in_re(in_re), .in_im(in_im), .min_valid(min_valid), .min_lzc(min_lzc),
        .out_valid(out_valid), .out_re(out_re), .out_im(out_im),
        .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_out(exp_out),
        .exp_full(exp_full), .err_sync(err_sync), .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          lane;
        logic [22:0] re;
        logic [22:0] im;
        logic [4:0]  lzc;
        logic [10:0] ore;
        logic [10:0] oim;
        logic [4:0]  sh;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        step();
    endtask

    // Zero-data group: the applied shift is just the clamped lzc.
    task automatic send_group(input logic [4:0] lzc, input logic ready_at_fire);
        in_valid = 1'b1;
        step();
        in_valid  = 1'b0;
        min_valid = 1'b1;
        min_lzc   = lzc;
        exp_ready = ready_at_fire;
        step();
        min_valid = 1'b0;
        exp_ready = 1'b0;
    endtask

    logic [LANES-1:0][IN_W-1:0]  re_v, im_v;
    logic [LANES-1:0][OUT_W-1:0] ore_v, oim_v;
    logic [4:0] exp_seq [8];

    initial begin
        vecs[0] = '{0, 23'h000200, 23'h000000, 5'd12, 11'h200, 11'h000, 5'd12};
        vecs[1] = '{3, 23'h000000, 23'h7FFE00, 5'd12, 11'h000, 11'h600, 5'd12};
        vecs[2] = '{0, 23'h000400, 23'h000000, 5'd11, 11'h200, 11'h000, 5'd11};
        vecs[3] = '{5, 23'h000000, 23'h000000, 5'd31, 11'h000, 11'h000, 5'd22};
        vecs[4] = '{7, 23'h0ABCDE, 23'h754322, 5'd1,  11'h157, 11'h6A8, 5'd1};
        vecs[5] = '{2, 23'h3FFFFF, 23'h400000, 5'd0,  11'h3FF, 11'h400, 5'd0};
        vecs[6] = '{4, 23'h000001, 23'h7FFFFF, 5'd21, 11'h200, 11'h600, 5'd21};
        exp_seq = '{5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd20};

        rstn = 1'b0; en = 1'b1; in_valid = 1'b0; in_re = '0; in_im = '0;
        min_valid = 1'b0; min_lzc = '0; exp_ready = 1'b0;
        step();
        step();
        rstn = 1'b1;
        step();

        check("rst_out_valid", out_valid, 0);
        check("rst_out_re", out_re, 0);
        check("rst_out_im", out_im, 0);
        check("rst_exp_valid", exp_valid, 0);
        check("rst_exp_out", exp_out, 0);
        check("rst_exp_full", exp_full, 0);
        check("rst_err_sync", err_sync, 0);
        check("rst_err_ovf", err_ovf, 0);

        for (int i = 0; i < 7; i++) begin
            re_v = '0; im_v = '0; ore_v = '0; oim_v = '0;
            re_v[vecs[i].lane]  = vecs[i].re;
            im_v[vecs[i].lane]  = vecs[i].im;
            ore_v[vecs[i].lane] = vecs[i].ore;
            oim_v[vecs[i].lane] = vecs[i].oim;
            in_re = re_v; in_im = im_v; in_valid = 1'b1;
            step();
            in_valid = 1'b0; in_re = '0; in_im = '0;
            check($sformatf("v%0d_early", i), out_valid, 0);
            min_valid = 1'b1; min_lzc = vecs[i].lzc;
            step();
            min_valid = 1'b0;
            check($sformatf("v%0d_valid", i), out_valid, 1);
            check($sformatf("v%0d_re", i), out_re, ore_v);
            check($sformatf("v%0d_im", i), out_im, oim_v);
            check($sformatf("v%0d_exp_valid", i), exp_valid, 1);
            check($sformatf("v%0d_exp_out", i), exp_out, vecs[i].sh);
            exp_ready = 1'b1;
            step();
            exp_ready = 1'b0;
            check($sformatf("v%0d_pulse", i), out_valid, 0);
            check($sformatf("v%0d_popped", i), exp_valid, 0);
        end
        check("aligned_err_sync", err_sync, 0);
        check("aligned_err_ovf", err_ovf, 0);

        // Fill the exponent FIFO, overflow it, then push+pop while full.
        for (int k = 0; k < 8; k++) send_group(5'(k + 1), 1'b0);
        check("fill_full", exp_full, 1);
        check("fill_no_ovf", err_ovf, 0);
        check("fill_head", exp_out, 1);
        send_group(5'd9, 1'b0);
        check("ovf_flag", err_ovf, 1);
        check("ovf_out_valid", out_valid, 1);
        check("ovf_full", exp_full, 1);
        check("ovf_head", exp_out, 1);
        send_group(5'd20, 1'b1);
        check("pp_full", exp_full, 1);
        check("pp_head", exp_out, 2);
        exp_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            check($sformatf("drain%0d", j), exp_out, exp_seq[j]);
            step();
        end
        check("drain_empty", exp_valid, 0);
        check("drain_not_full", exp_full, 0);
        step();
        check("pop_empty", exp_valid, 0);
        exp_ready = 1'b0;
        send_group(5'd5, 1'b0);
        check("after_empty_pop", exp_out, 5);
        check("after_empty_valid", exp_valid, 1);

        // Group with no lzc: dropped and flagged.
        do_reset();
        re_v = '0; re_v[0] = 23'h000200;
        in_re = re_v; in_valid = 1'b1;
        step();
        in_valid = 1'b0; in_re = '0;
        step();
        check("drop_err_sync", err_sync, 1);
        check("drop_out_valid", out_valid, 0);
        check("drop_exp_valid", exp_valid, 0);

        // Lzc with no group: ignored and flagged.
        do_reset();
        check("rst2_err_sync", err_sync, 0);
        min_valid = 1'b1; min_lzc = 5'd7;
        step();
        min_valid = 1'b0;
        check("orphan_err_sync", err_sync, 1);
        check("orphan_out_valid", out_valid, 0);
        check("orphan_exp_valid", exp_valid, 0);

        // Three-cycle stall between group and lzc.
        do_reset();
        re_v = '0; re_v[0] = 23'h000200; ore_v = '0; ore_v[0] = 11'h200;
        in_re = re_v; in_valid = 1'b1;
        step();
        in_valid = 1'b0; in_re = '0; en = 1'b0;
        for (int s = 0; s < 3; s++) begin
            step();
            check($sformatf("stall%0d_out_valid", s), out_valid, 0);
        end
        en = 1'b1; min_valid = 1'b1; min_lzc = 5'd12;
        step();
        min_valid = 1'b0;
        check("stall_out_valid", out_valid, 1);
        check("stall_out_re", out_re, ore_v);
        check("stall_exp_out", exp_out, 12);
        check("stall_err_sync", err_sync, 0);
        en = 1'b0;
        step();
        check("hold_out_valid", out_valid, 1);
        check("hold_out_re", out_re, ore_v);
        en = 1'b1;
        step();
        check("hold_release", out_valid, 0);
        check("hold_exp_valid", exp_valid, 1);

        // Reset with a group in flight.
        in_re = re_v; in_valid = 1'b1;
        step();
        in_valid = 1'b0; in_re = '0;
        rstn = 1'b0;
        #2;
        rstn = 1'b1;
        check("midrst_out_re", out_re, 0);
        check("midrst_exp_valid", exp_valid, 0);
        min_valid = 1'b1; min_lzc = 5'd12;
        step();
        min_valid = 1'b0;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_no_push", exp_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
